// File: rtl/waveform_capture.sv
// waveform_capture: pre-trigger delayed ADC window capture with pedestal, peak search and valid/ready readout
module waveform_capture #(
  parameter int DATA_W = 14,
  parameter int PRE = 6,
  parameter int LEN = 32,
  parameter int OFC_N = 5,
  parameter int PED_SHIFT = 3,
  localparam int AW = $clog2(LEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] adc_in,
  input  logic              trigger_in,
  output logic [DATA_W-1:0] result,
  output logic              long_trigger,
  output logic [DATA_W-1:0] pulse_height,
  output logic [AW-1:0]     peak_index,
  output logic [DATA_W-1:0] pedestal,
  output logic [DATA_W-1:0] ofc_data,
  output logic [2:0]        ofc_sample_num,
  output logic [DATA_W-1:0] wave_data,
  output logic              wave_valid,
  input  logic              wave_ready,
  output logic              wave_last,
  output logic [7:0]        missed_trig
);
  localparam logic [1:0] IDLE = 2'd0, CAPTURE = 2'd1, READOUT = 2'd2;
  localparam int ACC_W = DATA_W + PED_SHIFT;
  localparam logic [PED_SHIFT:0] CNT_MAX = (PED_SHIFT + 1)'((1 << PED_SHIFT) - 1);
  logic [1:0] state;
  logic [DATA_W-1:0] dly_line [PRE];
  logic [DATA_W-1:0] mem [LEN];
  logic [DATA_W-1:0] dly, peak;
  logic [AW:0] wr;
  logic [AW-1:0] wi, rd, peak_at;
  logic [ACC_W-1:0] acc, acc_sum;
  logic [PED_SHIFT:0] cnt;
  logic trig_d, start, we, fire;
  always_comb begin
    dly = dly_line[PRE-1];
    wi = wr[AW-1:0];
    start = state == IDLE && trigger_in;
    we = start || (state == CAPTURE && !wr[AW]);
    fire = wave_valid && wave_ready;
    acc_sum = acc + ACC_W'(dly);
    wave_data = wave_valid ? mem[rd] : '0;
    wave_last = wave_valid && rd == AW'(LEN - 1);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int j = 0; j < PRE; j++) dly_line[j] <= '0;
    else begin
      dly_line[0] <= adc_in;
      for (int j = 1; j < PRE; j++) dly_line[j] <= dly_line[j-1];
    end
  always_ff @(posedge clk) if (we) mem[wi] <= dly;
  // wr counts written samples; wr[AW] set means the window is complete
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      wr <= '0;
      rd <= '0;
      acc <= '0;
      cnt <= '0;
      peak <= '0;
      peak_at <= '0;
      trig_d <= 1'b0;
      result <= '0;
      long_trigger <= 1'b0;
      pulse_height <= '0;
      peak_index <= '0;
      pedestal <= '0;
      ofc_data <= '0;
      ofc_sample_num <= '0;
      wave_valid <= 1'b0;
      missed_trig <= '0;
    end else begin
      trig_d <= trigger_in;
      if (state != IDLE && trigger_in && !trig_d && missed_trig != 8'hff) missed_trig <= missed_trig + 8'd1;
      result <= we ? dly : '0;
      long_trigger <= we;
      ofc_data <= we && wi < AW'(OFC_N) ? dly : '0;
      ofc_sample_num <= we && wi < AW'(OFC_N) ? 3'(wi + 1'b1) : 3'd0;
      if (we) begin
        wr <= wr + 1'b1;
        if (wi == '0 || dly > peak) begin
          peak <= dly;
          peak_at <= wi;
        end
      end
      if (state == IDLE) begin
        acc <= start || cnt == CNT_MAX ? '0 : acc_sum;
        cnt <= start || cnt == CNT_MAX ? '0 : cnt + 1'b1;
        if (!start && cnt == CNT_MAX) pedestal <= DATA_W'(acc_sum >> PED_SHIFT);
        if (start) state <= CAPTURE;
      end else if (state == CAPTURE) begin
        if (wr[AW]) begin
          state <= READOUT;
          wr <= '0;
          rd <= '0;
          wave_valid <= 1'b1;
          pulse_height <= peak > pedestal ? peak - pedestal : '0;
          peak_index <= peak_at;
        end
      end else if (fire) begin
        rd <= rd + 1'b1;
        if (wave_last) begin
          wave_valid <= 1'b0;
          state <= IDLE;
        end
      end
    end
  end
endmodule
